// File: rtl/delay_sched.sv
// rtl/delay_sched.sv - round-robin scheduler sharing one programmable delay counter
module delay_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 19,
  parameter int MAXD  = 400000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] dly,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [CBITS-1:0]      cnt,
  output logic                  err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] MAXD_C = CBITS'(MAXD);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, own, own_n, win, idx;
  logic            found;
  logic [CBITS-1:0] tgt, tgt_n, cnt_n, dly_w;
  logic [NREQ-1:0] grant_n, done_n;
  logic            busy_n, viol;

  // Search starts one past the last owner, so the last owner has lowest priority.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign dly_w = dly[int'(win)*CBITS +: CBITS];

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    own_n   = own;
    tgt_n   = tgt;
    cnt_n   = cnt;
    grant_n = grant;
    done_n  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          own_n        = win;
          tgt_n        = (dly_w > MAXD_C) ? MAXD_C : dly_w;
          grant_n      = '0;
          grant_n[win] = 1'b1;
          cnt_n        = '0;
          state_n      = COUNT;
        end
      end
      COUNT: begin
        if (cnt == tgt) begin
          done_n  = grant;
          grant_n = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        ptr_n   = own;
        cnt_n   = '0;
        grant_n = '0;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // Invariants checked on the registered outputs; any hit latches err until reset.
  always_comb begin
    viol = (cnt > MAXD_C)
         || ((grant & (grant - 1'b1)) != '0)
         || ((done != '0) && (state != DONE))
         || ((grant != '0) && (state == IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= PW'(NREQ - 1);
      own   <= '0;
      tgt   <= '0;
      cnt   <= '0;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      own   <= own_n;
      tgt   <= tgt_n;
      cnt   <= cnt_n;
      grant <= grant_n;
      done  <= done_n;
      busy  <= busy_n;
      err   <= err | viol;
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// tb/tb_delay_sched.sv - randomized and directed bench for delay_sched
module tb_delay_sched;

  localparam int NREQ = 4;
  localparam int CBITS = 19;
  localparam int MAXD = 20;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req;
  logic [NREQ*CBITS-1:0] dly;
  logic [NREQ-1:0] grant, done;
  logic busy, err;
  logic [CBITS-1:0] cnt;

  int tests = 0;
  int fails = 0;

  delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .MAXD(MAXD)) dut (
    .clk(clk), .rst(rst), .req(req), .dly(dly),
    .grant(grant), .done(done), .busy(busy), .cnt(cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Job-schedule model: a job won at edge s owns the counter for edges s..s+tgt,
  // reports done at s+tgt+1, and the next arbitration happens at s+tgt+3.
  int n = 0;
  bit m_active = 0;
  int m_owner, m_start, m_tgt;
  int m_free = 0;
  int m_ptr = NREQ - 1;
  logic [NREQ-1:0] exp_grant, exp_done;
  logic exp_busy;
  logic [CBITS-1:0] exp_cnt;

  task automatic tick();
    logic [NREQ-1:0] r_s;
    logic [NREQ*CBITS-1:0] d_s;
    logic rs_s;
    int d;
    r_s = req; d_s = dly; rs_s = rst;
    @(posedge clk);
    n++;
    if (rs_s) begin
      m_active = 0; m_ptr = NREQ - 1; m_free = n + 1;
    end else begin
      if (m_active && n == m_start + m_tgt + 2) begin
        m_active = 0; m_ptr = m_owner; m_free = n + 1;
      end
      if (!m_active && n >= m_free && r_s != 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!m_active && r_s[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            m_active = 1;
          end
        end
        d = int'(d_s[m_owner*CBITS +: CBITS]);
        m_tgt = (d > MAXD) ? MAXD : d;
        m_start = n;
      end
    end
    exp_grant = '0; exp_done = '0; exp_busy = 1'b0; exp_cnt = '0;
    if (m_active) begin
      if (n <= m_start + m_tgt) begin
        exp_grant = NREQ'(1) << m_owner; exp_cnt = CBITS'(n - m_start); exp_busy = 1'b1;
      end else if (n == m_start + m_tgt + 1) begin
        exp_done = NREQ'(1) << m_owner; exp_cnt = CBITS'(m_tgt); exp_busy = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; dly = '0;
    tick(); tick();
    tests++; if (grant !== '0) begin fails++; $display("FAIL reset_grant got %b want 0", grant); end
    tests++; if (done !== '0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (cnt !== '0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int gc = 0, dc = 0, bc = 0;
    dly[0*CBITS +: CBITS] = 5; req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      req = '0;
      if (grant == 4'b0001) gc++;
      if (done == 4'b0001) dc++;
      if (busy) bc++;
      tests++;
      if ({grant, done, busy, cnt, err} !== {exp_grant, exp_done, exp_busy, exp_cnt, 1'b0}) begin
        fails++; $display("FAIL single_cycle%0d got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                          c, grant, done, busy, cnt, exp_grant, exp_done, exp_busy, exp_cnt);
      end
    end
    tests++; if (gc != 6) begin fails++; $display("FAIL single_grant_len got %0d want 6", gc); end
    tests++; if (dc != 1) begin fails++; $display("FAIL single_done_count got %0d want 1", dc); end
    tests++; if (bc != 7) begin fails++; $display("FAIL single_busy_len got %0d want 7", bc); end
  endtask

  task automatic test_zero_clamp();
    int gc = 0;
    int peak = 0;
    dly[1*CBITS +: CBITS] = 0; req = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      tick(); req = '0;
      if (grant[1]) gc++;
    end
    tests++; if (gc != 1) begin fails++; $display("FAIL zero_grant_len got %0d want 1", gc); end
    gc = 0;
    dly[2*CBITS +: CBITS] = 1000; req = 4'b0100;
    for (int c = 0; c < 30; c++) begin
      tick(); req = '0;
      if (grant[2]) gc++;
      if (int'(cnt) > peak) peak = int'(cnt);
      tests++;
      if ({grant, done, busy, cnt, err} !== {exp_grant, exp_done, exp_busy, exp_cnt, 1'b0}) begin
        fails++; $display("FAIL clamp_cycle%0d got g=%b d=%b c=%0d e=%b want g=%b d=%b c=%0d",
                          c, grant, done, cnt, err, exp_grant, exp_done, exp_cnt);
      end
    end
    tests++; if (gc != 21) begin fails++; $display("FAIL clamp_grant_len got %0d want 21", gc); end
    tests++; if (peak != 20) begin fails++; $display("FAIL clamp_cnt_peak got %0d want 20", peak); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int lows = 0;
    logic [NREQ-1:0] prev = '0;
    int want[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) dly[i*CBITS +: CBITS] = 2;
    req = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (grant != '0 && prev == '0) begin
        for (int i = 0; i < NREQ; i++) if (grant[i]) order.push_back(i);
        if (order.size() > 1) begin
          tests++;
          if (lows != 2) begin fails++; $display("FAIL rr_gap got %0d want 2", lows); end
        end
      end
      if (grant == '0) lows++; else lows = 0;
      prev = grant;
      tests++;
      if ({grant, done, busy, cnt} !== {exp_grant, exp_done, exp_busy, exp_cnt}) begin
        fails++; $display("FAIL rr_cycle%0d got g=%b d=%b want g=%b d=%b", c, grant, done, exp_grant, exp_done);
      end
    end
    req = '0;
    for (int c = 0; c < 6; c++) tick();
    tests++;
    if (order.size() < 5) begin
      fails++; $display("FAIL rr_count got %0d want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (order[i] != want[i]) begin fails++; $display("FAIL rr_order%0d got %0d want %0d", i, order[i], want[i]); end
      end
    end
  endtask

  task automatic test_mid_job();
    int gc = 0, dc = 0;
    dly[0*CBITS +: CBITS] = 8; req = 4'b0001;
    tick();
    req = '0; dly[0*CBITS +: CBITS] = 1;
    if (grant[0]) gc++;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (grant[0]) gc++;
      if (done[0]) dc++;
    end
    tests++; if (gc != 9) begin fails++; $display("FAIL midjob_grant_len got %0d want 9", gc); end
    tests++; if (dc != 1) begin fails++; $display("FAIL midjob_done_count got %0d want 1", dc); end
  endtask

  task automatic test_reset_mid_count();
    int budget = 0;
    int dc = 0;
    dly[0*CBITS +: CBITS] = 9; req = 4'b0001;
    tick(); req = '0;
    while (cnt != 3 && budget < 20) begin tick(); budget++; end
    tests++;
    if (cnt != 3) begin fails++; $display("FAIL rstmid_reach got cnt=%0d want 3", cnt); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++;
    if ({grant, done, busy, cnt, err} !== '0) begin
      fails++; $display("FAIL rstmid_outputs got g=%b d=%b b=%b c=%0d e=%b want all 0", grant, done, busy, cnt, err);
    end
    // ptr back at NREQ-1 means requester 0 wins over 1.
    req = 4'b0011;
    tick(); req = '0;
    if (done != '0) dc++;
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL rstmid_regrant got %b want 0001", grant); end
    for (int c = 0; c < 4; c++) begin tick(); if (done != '0) dc++; end
    tests++; if (dc != 0) begin fails++; $display("FAIL rstmid_no_done got %0d pulses want 0", dc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 20000; c++) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) dly[i*CBITS +: CBITS] = CBITS'($urandom_range(0, 31));
      rst = ($urandom_range(0, 999) == 0);
      tick();
      tests++;
      if ({grant, done, busy, cnt, err} !== {exp_grant, exp_done, exp_busy, exp_cnt, 1'b0}) begin
        fails++; $display("FAIL random_cycle%0d got g=%b d=%b b=%b c=%0d e=%b want g=%b d=%b b=%b c=%0d",
                          c, grant, done, busy, cnt, err, exp_grant, exp_done, exp_busy, exp_cnt);
      end
      tests++;
      if ((grant & (grant - 1'b1)) !== '0) begin
        fails++; $display("FAIL random_onehot got %b want one-hot-or-zero", grant);
      end
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_clamp();
    test_round_robin();
    test_mid_job();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
